// File: rtl/spi_slave_sync.sv
// Mode-0 SPI slave. The SPI pins are oversampled on CLK, so no logic runs on the SPI clock.
// Receives MSB-first words, shifts a parallel word out on MISO, and mirrors low RX bits to LEDs.
module spi_slave_sync #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LED_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                SLK,
    input  logic                MOSI,
    input  logic                CS,
    output logic                MISO,
    output logic                MISO_OE,
    input  logic [WIDTH-1:0]    TX_DATA,
    output logic                TX_ACK,
    output logic [WIDTH-1:0]    RX_DATA,
    output logic                RX_VALID,
    output logic                ABORT,
    output logic [LED_BITS-1:0] LED
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic {StIdle, StActive} state_e;

    state_e              state_q, state_d;
    logic [2:0]          slk_sync_q, slk_sync_d;
    logic [2:0]          cs_sync_q, cs_sync_d;
    logic [1:0]          mosi_sync_q, mosi_sync_d;
    logic                slk_rise_q, slk_rise_d;
    logic                slk_fall_q, slk_fall_d;
    logic                cs_fall_q, cs_fall_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0]    rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]    tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]    rx_data_q, rx_data_d;
    logic [LED_BITS-1:0] led_q, led_d;
    logic                word_done_q, word_done_d;
    logic                miso_q, miso_d;
    logic                miso_oe_q, miso_oe_d;
    logic                tx_ack_q, tx_ack_d;
    logic                rx_valid_q, rx_valid_d;
    logic                abort_q, abort_d;
    logic [WIDTH-1:0]    rx_word;

    always_comb begin
        slk_sync_d  = {slk_sync_q[1:0], SLK};
        cs_sync_d   = {cs_sync_q[1:0], CS};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        // Edge strobes are registered so they line up with the third-stage level of CS.
        slk_rise_d  = slk_sync_q[1] & ~slk_sync_q[2];
        slk_fall_d  = ~slk_sync_q[1] & slk_sync_q[2];
        cs_fall_d   = ~cs_sync_q[1] & cs_sync_q[2];

        rx_word     = {rx_shift_q, mosi_sync_q[1]};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        led_d       = led_q;
        word_done_d = word_done_q;
        tx_ack_d    = 1'b0;
        rx_valid_d  = 1'b0;
        abort_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall_q) begin
                    state_d     = StActive;
                    tx_shift_d  = TX_DATA;
                    tx_ack_d    = 1'b1;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    word_done_d = 1'b0;
                end
            end
            StActive: begin
                // CS deselect takes priority over any SLK event in the same cycle.
                if (cs_sync_q[2]) begin
                    state_d   = StIdle;
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else if (slk_rise_q) begin
                    rx_shift_d = rx_word[WIDTH-2:0];
                    if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                        bit_cnt_d   = '0;
                        rx_data_d   = rx_word;
                        led_d       = rx_word[LED_BITS-1:0];
                        rx_valid_d  = 1'b1;
                        word_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (slk_fall_q) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                    end else if (word_done_q) begin
                        tx_shift_d = TX_DATA;
                        tx_ack_d   = 1'b1;
                    end
                end
            end
        endcase

        miso_oe_d = (state_d == StActive);
        miso_d    = (state_d == StActive) & tx_shift_d[WIDTH-1];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            slk_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            slk_rise_q  <= 1'b0;
            slk_fall_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            led_q       <= '0;
            word_done_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slk_sync_q  <= slk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            slk_rise_q  <= slk_rise_d;
            slk_fall_q  <= slk_fall_d;
            cs_fall_q   <= cs_fall_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            led_q       <= led_d;
            word_done_q <= word_done_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_ack_q    <= tx_ack_d;
            rx_valid_q  <= rx_valid_d;
            abort_q     <= abort_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_OE  = miso_oe_q;
    assign TX_ACK   = tx_ack_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign ABORT    = abort_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an 8-bit and a 16-bit instance share the SPI pins driven by a
// behavioural mode-0 master; pulses are counted on the falling CLK edge.
module tb_spi_slave_sync;
    localparam int Half = 6;

    logic        clk = 1'b0;
    logic        rst_n, slk, mosi, cs, use16;
    logic [7:0]  tx8;
    logic [15:0] tx16;
    logic        miso8, miso_oe8, tx_ack8, rx_valid8, abort8;
    logic [7:0]  rx_data8;
    logic [3:0]  led8;
    logic        miso16, miso_oe16, tx_ack16, rx_valid16, abort16;
    logic [15:0] rx_data16;
    logic [7:0]  led16;
    logic        miso_mux;

    int checks = 0, errors = 0;
    int rxv8 = 0, ack8 = 0, abt8 = 0, rxv16 = 0;
    int b_rxv8, b_ack8, b_abt8, b_rxv16;
    logic [7:0] rxw8 [16];

    always #5 clk = ~clk;
    assign miso_mux = use16 ? miso16 : miso8;

    spi_slave_sync #(.WIDTH(8), .LED_BITS(4)) dut8 (
        .CLK(clk), .RST_N(rst_n), .SLK(slk), .MOSI(mosi), .CS(cs),
        .MISO(miso8), .MISO_OE(miso_oe8), .TX_DATA(tx8), .TX_ACK(tx_ack8),
        .RX_DATA(rx_data8), .RX_VALID(rx_valid8), .ABORT(abort8), .LED(led8)
    );

    spi_slave_sync #(.WIDTH(16), .LED_BITS(8)) dut16 (
        .CLK(clk), .RST_N(rst_n), .SLK(slk), .MOSI(mosi), .CS(cs),
        .MISO(miso16), .MISO_OE(miso_oe16), .TX_DATA(tx16), .TX_ACK(tx_ack16),
        .RX_DATA(rx_data16), .RX_VALID(rx_valid16), .ABORT(abort16), .LED(led16)
    );

    always @(negedge clk) begin
        if (rx_valid8) begin
            rxw8[rxv8 % 16] = rx_data8;
            rxv8++;
        end
        if (tx_ack8) ack8++;
        if (abort8) abt8++;
        if (rx_valid16) rxv16++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_rxv8  = rxv8;
        b_ack8  = ack8;
        b_abt8  = abt8;
        b_rxv16 = rxv16;
    endtask

    // Shift n bits MSB-first; end_frame raises CS together with the final SLK fall.
    task automatic spi_bits(input int n, input logic [31:0] tx, input bit end_frame,
                            output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            step(Half);
            slk = 1'b1;
            rx = {rx[30:0], miso_mux};
            step(Half);
            slk = 1'b0;
            if (i == 0 && end_frame) cs = 1'b1;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] tx, output logic [31:0] rx);
        cs = 1'b0;
        step(Half);
        spi_bits(n, tx, 1'b1, rx);
        step(Half + 4);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        logic [3:0] exp_led;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] got, got2;

    initial begin
        vecs[0] = '{tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_led: 4'hC};
        vecs[1] = '{tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00, exp_led: 4'hF};
        vecs[2] = '{tx: 8'hFF, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF, exp_led: 4'h0};
        vecs[3] = '{tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h5A, exp_led: 4'h3};

        rst_n = 1'b0; cs = 1'b0; slk = 1'b0; mosi = 1'b1; use16 = 1'b0;
        tx8 = 8'h00; tx16 = 16'h0000;

        // Reset with CS low and SLK toggling
        repeat (3) begin
            step(1);
            slk = ~slk;
        end
        slk = 1'b0;
        step(1);
        check("reset_outputs", {23'd0, miso8, miso_oe8, tx_ack8, rx_valid8, abort8, led8},
              32'd0);
        check("reset_rx_data", {24'd0, rx_data8}, 32'd0);
        check("reset_rx_data16", {16'd0, rx_data16}, 32'd0);
        rst_n = 1'b1;
        snap();
        spi_bits(8, 32'hFF, 1'b1, got);
        step(Half + 4);
        check("post_reset_no_valid", rxv8 - b_rxv8, 0);
        check("post_reset_no_ack", ack8 - b_ack8, 0);
        check("post_reset_no_abort", abt8 - b_abt8, 0);
        check("post_reset_rx_data", {24'd0, rx_data8}, 32'd0);

        // Single-word frames from the vector table
        for (int v = 0; v < 4; v++) begin
            tx8 = vecs[v].tx;
            snap();
            frame(8, {24'd0, vecs[v].mosi}, got);
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data8}, {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_rx_log", v), {24'd0, rxw8[b_rxv8 % 16]},
                  {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_miso", v), got, {24'd0, vecs[v].exp_miso});
            check($sformatf("v%0d_led", v), {28'd0, led8}, {28'd0, vecs[v].exp_led});
            check($sformatf("v%0d_valid_cnt", v), rxv8 - b_rxv8, 1);
            check($sformatf("v%0d_ack_cnt", v), ack8 - b_ack8, 1);
            check($sformatf("v%0d_abort_cnt", v), abt8 - b_abt8, 0);
            check($sformatf("v%0d_oe_idle", v), {31'd0, miso_oe8}, 32'd0);
        end

        // Two words in one frame, TX_DATA changed after the first TX_ACK
        tx8 = 8'h81;
        snap();
        cs = 1'b0;
        step(Half);
        check("two_oe_active", {31'd0, miso_oe8}, 32'd1);
        check("two_first_ack", ack8 - b_ack8, 1);
        tx8 = 8'h7E;
        spi_bits(8, 32'h12, 1'b0, got);
        spi_bits(8, 32'h34, 1'b1, got2);
        step(Half + 4);
        check("two_miso_w0", got, 32'h81);
        check("two_miso_w1", got2, 32'h7E);
        check("two_valid_cnt", rxv8 - b_rxv8, 2);
        check("two_rx_w0", {24'd0, rxw8[b_rxv8 % 16]}, 32'h12);
        check("two_rx_w1", {24'd0, rxw8[(b_rxv8 + 1) % 16]}, 32'h34);
        check("two_ack_cnt", ack8 - b_ack8, 2);
        check("two_led", {28'd0, led8}, 32'h4);

        // Abort after 5 bits of 0xFF
        snap();
        cs = 1'b0;
        step(Half);
        spi_bits(5, 32'h1F, 1'b0, got);
        step(Half);
        cs = 1'b1;
        step(Half + 4);
        check("abort_cnt", abt8 - b_abt8, 1);
        check("abort_no_valid", rxv8 - b_rxv8, 0);
        check("abort_rx_kept", {24'd0, rx_data8}, 32'h34);
        check("abort_oe_low", {31'd0, miso_oe8}, 32'd0);
        check("abort_miso_low", {31'd0, miso8}, 32'd0);

        // CS and the 8th SLK rise land together: the bit must not be taken
        snap();
        cs = 1'b0;
        step(Half);
        spi_bits(7, 32'h7F, 1'b0, got);
        mosi = 1'b1;
        step(Half);
        slk = 1'b1;
        cs  = 1'b1;
        step(Half);
        slk = 1'b0;
        step(Half + 4);
        check("simul_abort_cnt", abt8 - b_abt8, 1);
        check("simul_no_valid", rxv8 - b_rxv8, 0);
        check("simul_rx_kept", {24'd0, rx_data8}, 32'h34);

        // Trailing SLK fall before CS rise reloads TX_DATA once more
        tx8 = 8'h11;
        snap();
        cs = 1'b0;
        step(Half);
        spi_bits(8, 32'h22, 1'b0, got);
        step(Half);
        cs = 1'b1;
        step(Half + 4);
        check("trail_miso", got, 32'h11);
        check("trail_ack_cnt", ack8 - b_ack8, 2);
        check("trail_abort_cnt", abt8 - b_abt8, 0);
        check("trail_rx_data", {24'd0, rx_data8}, 32'h22);

        // Reset mid-frame; the rest of that frame is ignored
        snap();
        cs = 1'b0;
        step(Half);
        spi_bits(3, 32'h5, 1'b0, got);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        spi_bits(5, 32'h1F, 1'b1, got);
        step(Half + 4);
        check("midrst_no_valid", rxv8 - b_rxv8, 0);
        check("midrst_no_abort", abt8 - b_abt8, 0);
        check("midrst_rx_cleared", {24'd0, rx_data8}, 32'd0);
        check("midrst_led_cleared", {28'd0, led8}, 32'd0);
        tx8 = 8'hC3;
        snap();
        frame(8, 32'h96, got);
        check("midrst_next_rx", {24'd0, rx_data8}, 32'h96);
        check("midrst_next_miso", got, 32'hC3);
        check("midrst_next_led", {28'd0, led8}, 32'h6);
        check("midrst_next_valid", rxv8 - b_rxv8, 1);

        // 16-bit instance
        use16 = 1'b1;
        tx16 = 16'h1234;
        snap();
        frame(16, 32'hBEEF, got);
        check("w16_rx_data", {16'd0, rx_data16}, 32'hBEEF);
        check("w16_led", {24'd0, led16}, 32'hEF);
        check("w16_miso", got, 32'h1234);
        check("w16_valid_cnt", rxv16 - b_rxv16, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
